// File: rtl/l2_cache_pkg.sv
// Shared types and address-split helpers for the write-back L2 cache.
package l2_cache_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StWriteback,
        StFill,
        StRespond
    } state_t;

    function automatic int unsigned off_width(input int unsigned block_words);
        return $clog2(block_words);
    endfunction

    function automatic int unsigned idx_width(input int unsigned num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int unsigned tag_width(input int unsigned addr_width,
                                              input int unsigned block_words,
                                              input int unsigned num_sets);
        return addr_width - off_width(block_words) - idx_width(num_sets);
    endfunction

    // A single-way cache still needs a one-bit way index.
    function automatic int unsigned way_width(input int unsigned num_ways);
        return (num_ways > 1) ? $clog2(num_ways) : 1;
    endfunction

    // Extract a bit field from an address; callers narrow the result to the field width.
    function automatic logic [63:0] addr_field(input logic [63:0] addr,
                                               input int unsigned lsb,
                                               input int unsigned width);
        return (addr >> lsb) & ((64'd1 << width) - 64'd1);
    endfunction

endpackage

// File: rtl/l2_cache_wb_victim_select.sv
// Miss victim choice: lowest invalid way first, otherwise the set's round-robin pointer.
module l2_victim_select
    import l2_cache_pkg::*;
#(
    parameter int unsigned NUM_WAYS = 4,
    parameter int unsigned WAY_W    = 2
) (
    input  logic [NUM_WAYS-1:0] valid,
    input  logic [WAY_W-1:0]    rr_ptr,
    output logic [WAY_W-1:0]    victim_way,
    output logic                used_pointer
);

    // Scan from the top down so the lowest invalid way is the one left standing.
    always_comb begin
        victim_way   = rr_ptr;
        used_pointer = 1'b1;
        for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
            if (!valid[w]) begin
                victim_way   = WAY_W'(w);
                used_pointer = 1'b0;
            end
        end
    end

endmodule

// File: rtl/l2_cache_wb.sv
// Set-associative write-back, write-allocate L2 cache with one outstanding request.
module l2_cache_wb
    import l2_cache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned BLOCK_WORDS    = 16,
    parameter int unsigned L1_BLOCK_WORDS = 4,
    parameter int unsigned NUM_SETS       = 16,
    parameter int unsigned NUM_WAYS       = 4,
    parameter int unsigned HIT_LATENCY    = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [ADDR_WIDTH-1:0]                req_addr,
    input  logic [L1_BLOCK_WORDS*DATA_WIDTH-1:0] req_wdata,
    input  logic                                 req_read,
    input  logic                                 req_write,
    output logic [L1_BLOCK_WORDS*DATA_WIDTH-1:0] req_rdata,
    output logic                                 req_ready,
    output logic                                 req_hit,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    output logic [BLOCK_WORDS*DATA_WIDTH-1:0]    mem_wdata,
    input  logic [BLOCK_WORDS*DATA_WIDTH-1:0]    mem_rdata,
    output logic                                 mem_read,
    output logic                                 mem_write,
    input  logic                                 mem_ready
);

    localparam int unsigned OFF_W  = off_width(BLOCK_WORDS);
    localparam int unsigned IDX_W  = idx_width(NUM_SETS);
    localparam int unsigned TAG_W  = tag_width(ADDR_WIDTH, BLOCK_WORDS, NUM_SETS);
    localparam int unsigned WAY_W  = way_width(NUM_WAYS);
    localparam int unsigned LINE_W = BLOCK_WORDS * DATA_WIDTH;
    localparam int unsigned SUB_W  = L1_BLOCK_WORDS * DATA_WIDTH;
    localparam int unsigned CNT_W  = $clog2(HIT_LATENCY) + 1;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [SUB_W-1:0]       wdata_q;
    logic                   is_write_q;
    logic [WAY_W-1:0]       victim_q;
    logic                   used_ptr_q;

    logic [TAG_W-1:0]       tag_q   [NUM_SETS][NUM_WAYS];
    logic [LINE_W-1:0]      data_q  [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]    valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]    dirty_q [NUM_SETS];
    logic [WAY_W-1:0]       rr_q    [NUM_SETS];

    logic [TAG_W-1:0]       req_tag;
    logic [IDX_W-1:0]       req_idx;
    logic [OFF_W-1:0]       sub_start;
    logic [ADDR_WIDTH-1:0]  fill_addr;
    logic                   hit;
    logic [WAY_W-1:0]       hit_way;
    logic [WAY_W-1:0]       vs_way;
    logic                   vs_used;
    logic                   lookup_done;
    logic                   arr_we;
    logic [WAY_W-1:0]       arr_way;
    logic [LINE_W-1:0]      arr_line;

    assign req_tag     = TAG_W'(addr_field(64'(addr_q), OFF_W + IDX_W, TAG_W));
    assign req_idx     = IDX_W'(addr_field(64'(addr_q), OFF_W, IDX_W));
    assign sub_start   = OFF_W'(addr_field(64'(addr_q), 0, OFF_W)) &
                         ~OFF_W'(L1_BLOCK_WORDS - 1);
    assign fill_addr   = {req_tag, req_idx, {OFF_W{1'b0}}};
    assign lookup_done = (state_q == StLookup) && (cnt_q == '0);

    function automatic logic [SUB_W-1:0] get_sub(input logic [LINE_W-1:0] line,
                                                 input logic [OFF_W-1:0]  start);
        logic [SUB_W-1:0] sub;
        for (int i = 0; i < int'(L1_BLOCK_WORDS); i++) begin
            sub[i*DATA_WIDTH +: DATA_WIDTH] = line[(int'(start) + i)*DATA_WIDTH +: DATA_WIDTH];
        end
        return sub;
    endfunction

    function automatic logic [LINE_W-1:0] merge_sub(input logic [LINE_W-1:0] line,
                                                    input logic [SUB_W-1:0]  sub,
                                                    input logic [OFF_W-1:0]  start);
        logic [LINE_W-1:0] res;
        res = line;
        for (int i = 0; i < int'(L1_BLOCK_WORDS); i++) begin
            res[(int'(start) + i)*DATA_WIDTH +: DATA_WIDTH] = sub[i*DATA_WIDTH +: DATA_WIDTH];
        end
        return res;
    endfunction

    l2_victim_select #(
        .NUM_WAYS (NUM_WAYS),
        .WAY_W    (WAY_W)
    ) u_victim_select (
        .valid        (valid_q[req_idx]),
        .rr_ptr       (rr_q[req_idx]),
        .victim_way   (vs_way),
        .used_pointer (vs_used)
    );

    // Tag compare across the ways of the addressed set; lowest matching way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:      if (req_write || req_read) state_d = StLookup;
            StLookup: begin
                if (cnt_q == '0) begin
                    if (hit) begin
                        state_d = StRespond;
                    end else if (valid_q[req_idx][vs_way] && dirty_q[req_idx][vs_way]) begin
                        state_d = StWriteback;
                    end else begin
                        state_d = StFill;
                    end
                end
            end
            StWriteback: if (mem_ready) state_d = StFill;
            StFill:      if (mem_ready) state_d = StRespond;
            StRespond:   state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    // Data/tag array write port: write hits merge in place, fills install the new line.
    always_comb begin
        arr_we   = 1'b0;
        arr_way  = hit_way;
        arr_line = data_q[req_idx][hit_way];
        if (lookup_done && hit && is_write_q) begin
            arr_we   = 1'b1;
            arr_line = merge_sub(data_q[req_idx][hit_way], wdata_q, sub_start);
        end else if ((state_q == StFill) && mem_ready) begin
            arr_we   = 1'b1;
            arr_way  = victim_q;
            arr_line = is_write_q ? merge_sub(mem_rdata, wdata_q, sub_start) : mem_rdata;
        end
    end

    // Data and tag arrays carry no reset; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && arr_we) begin
            data_q[req_idx][arr_way] <= arr_line;
            tag_q[req_idx][arr_way]  <= req_tag;
        end
    end

    // Control state, request capture, line metadata and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            victim_q   <= '0;
            used_ptr_q <= 1'b0;
            req_rdata  <= '0;
            req_ready  <= 1'b0;
            req_hit    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            for (int s = 0; s < int'(NUM_SETS); s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state_q   <= state_d;
            req_ready <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_write || req_read) begin
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        is_write_q <= req_write;
                        cnt_q      <= CNT_W'(HIT_LATENCY - 1);
                    end
                end
                StLookup: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (hit) begin
                        req_ready <= 1'b1;
                        req_hit   <= 1'b1;
                        if (is_write_q) begin
                            dirty_q[req_idx][hit_way] <= 1'b1;
                        end else begin
                            req_rdata <= get_sub(data_q[req_idx][hit_way], sub_start);
                        end
                    end else begin
                        victim_q   <= vs_way;
                        used_ptr_q <= vs_used;
                        if (valid_q[req_idx][vs_way] && dirty_q[req_idx][vs_way]) begin
                            mem_write <= 1'b1;
                            mem_addr  <= {tag_q[req_idx][vs_way], req_idx, {OFF_W{1'b0}}};
                            mem_wdata <= data_q[req_idx][vs_way];
                        end else begin
                            mem_read <= 1'b1;
                            mem_addr <= fill_addr;
                        end
                    end
                end
                StWriteback: begin
                    if (mem_ready) begin
                        mem_write <= 1'b0;
                        mem_read  <= 1'b1;
                        mem_addr  <= fill_addr;
                    end
                end
                StFill: begin
                    if (mem_ready) begin
                        mem_read                   <= 1'b0;
                        valid_q[req_idx][victim_q] <= 1'b1;
                        dirty_q[req_idx][victim_q] <= is_write_q;
                        if (!is_write_q) req_rdata <= get_sub(mem_rdata, sub_start);
                        // Only a pointer-chosen victim advances the pointer.
                        if (used_ptr_q) begin
                            rr_q[req_idx] <= (victim_q == WAY_W'(NUM_WAYS - 1)) ?
                                             '0 : victim_q + 1'b1;
                        end
                        req_ready <= 1'b1;
                        req_hit   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_cache_wb.sv
// Self-checking bench for l2_cache_wb: vector table, scoreboard queue and a memory model.
module tb_l2_cache_wb;

    localparam int unsigned LINE_W = 16 * 32;
    localparam int unsigned SUB_W  = 4 * 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       req_addr;
    logic [SUB_W-1:0]  req_wdata;
    logic              req_read, req_write;
    logic [SUB_W-1:0]  req_rdata;
    logic              req_ready, req_hit;
    logic [31:0]       mem_addr;
    logic [LINE_W-1:0] mem_wdata, mem_rdata;
    logic              mem_read, mem_write, mem_ready;

    int errors = 0;
    int checks = 0;
    int overlap = 0;
    bit mem_hold = 1'b0;

    typedef struct {
        string            name;
        logic             hit;
        logic [SUB_W-1:0] rdata;
    } exp_t;

    typedef struct {
        logic              wr;
        logic [31:0]       addr;
        logic [LINE_W-1:0] data;
    } mem_ev_t;

    typedef struct {
        string            name;
        logic [31:0]      addr;
        logic             rd;
        logic             wr;
        logic [SUB_W-1:0] wd;
        logic             hit;
        logic [SUB_W-1:0] rdata;
        int               lat;
        int               ops;
    } vec_t;

    exp_t              sb_q[$];
    mem_ev_t           mem_log[$];
    vec_t              vecs[$];
    logic [LINE_W-1:0] mem_store [logic [31:0]];

    l2_cache_wb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_read  (req_read),
        .req_write (req_write),
        .req_rdata (req_rdata),
        .req_ready (req_ready),
        .req_hit   (req_hit),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    // Backing-store contents for lines never written back: word k = ((line - 0x100) << 12) | k.
    function automatic logic [LINE_W-1:0] pattern_line(input logic [31:0] la);
        logic [LINE_W-1:0] l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = ((la - 32'h100) << 12) | 32'(k);
        return l;
    endfunction

    function automatic logic [SUB_W-1:0] sub_of(input logic [LINE_W-1:0] l, input int start);
        return l[start*32 +: SUB_W];
    endfunction

    task automatic check(input string name, input logic [LINE_W-1:0] act,
                         input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: answers a held mem_read/mem_write after three cycles.
    initial begin
        int wait_cnt;
        wait_cnt  = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (mem_read && mem_write) overlap++;
            if (!rst_n || mem_hold || !(mem_read || mem_write)) begin
                wait_cnt = 0;
            end else if (wait_cnt < 2) begin
                wait_cnt++;
            end else begin
                mem_ev_t ev;
                wait_cnt  = 0;
                mem_ready = 1'b1;
                ev.wr     = mem_write;
                ev.addr   = mem_addr;
                if (mem_write) begin
                    ev.data              = mem_wdata;
                    mem_store[mem_addr]  = mem_wdata;
                end else begin
                    mem_rdata = mem_store.exists(mem_addr) ? mem_store[mem_addr]
                                                           : pattern_line(mem_addr);
                    ev.data   = mem_rdata;
                end
                mem_log.push_back(ev);
            end
        end
    end

    // Scoreboard consumer: every completion pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && req_ready) begin
            if (sb_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_ready: got req_ready=1 expected no response");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.name, "_hit"}, LINE_W'(req_hit), LINE_W'(e.hit));
                check({e.name, "_rdata"}, LINE_W'(req_rdata), LINE_W'(e.rdata));
            end
        end
    end

    task automatic do_req(input string name, input logic [31:0] addr, input logic rd,
                          input logic wr, input logic [SUB_W-1:0] wd, input logic exp_hit,
                          input logic [SUB_W-1:0] exp_rd, input int exp_lat,
                          input int exp_ops);
        exp_t e;
        int   lat;
        e.name  = name;
        e.hit   = exp_hit;
        e.rdata = exp_rd;
        @(negedge clk);
        mem_log.delete();
        sb_q.push_back(e);
        req_addr  = addr;
        req_read  = rd;
        req_write = wr;
        req_wdata = wd;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!req_ready && lat < 200);
        req_read  = 1'b0;
        req_write = 1'b0;
        if (!req_ready) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: got no req_ready expected one within 200 cycles", name);
            void'(sb_q.pop_back());
        end
        if (exp_lat > 0) check({name, "_latency"}, LINE_W'(lat), LINE_W'(exp_lat));
        check({name, "_mem_ops"}, LINE_W'(mem_log.size()), LINE_W'(exp_ops));
    endtask

    function automatic void add_vec(input string name, input logic [31:0] addr,
                                    input logic rd, input logic wr, input logic [SUB_W-1:0] wd,
                                    input logic hit, input logic [SUB_W-1:0] rdata,
                                    input int lat, input int ops);
        vec_t v;
        v.name = name; v.addr = addr; v.rd = rd; v.wr = wr; v.wd = wd;
        v.hit = hit; v.rdata = rdata; v.lat = lat; v.ops = ops;
        vecs.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [SUB_W-1:0]  wa, we, wf;
        logic [LINE_W-1:0] wb_line;
        int                n;
        wa = {32'h0000_000D, 32'h0000_000C, 32'h0000_000B, 32'h0000_000A};
        we = {32'hE000_0004, 32'hE000_0003, 32'hE000_0002, 32'hE000_0001};
        wf = {32'hF000_0004, 32'hF000_0003, 32'hF000_0002, 32'hF000_0001};

        add_vec("hit_read",      32'h104, 1, 0, '0, 1, sub_of(pattern_line(32'h100), 4), 3, 0);
        add_vec("write_hit",     32'h108, 0, 1, wa, 1, sub_of(pattern_line(32'h100), 4), 3, 0);
        add_vec("read_written",  32'h108, 1, 0, '0, 1, wa, 3, 0);
        add_vec("read_neighbor", 32'h104, 1, 0, '0, 1, sub_of(pattern_line(32'h100), 4), 0, 0);
        add_vec("rd_and_wr",     32'h10C, 1, 1, we, 1, sub_of(pattern_line(32'h100), 4), 0, 0);
        add_vec("read_both",     32'h10C, 1, 0, '0, 1, we, 0, 0);
        add_vec("miss_set0",     32'h200, 1, 0, '0, 0, sub_of(pattern_line(32'h200), 0), 0, 1);
        add_vec("write_miss",    32'h314, 0, 1, wf, 0, sub_of(pattern_line(32'h200), 0), 0, 1);
        add_vec("read_alloc",    32'h314, 1, 0, '0, 1, wf, 0, 0);
        add_vec("read_alloc_nb", 32'h318, 1, 0, '0, 1, sub_of(pattern_line(32'h310), 8), 0, 0);

        rst_n = 1'b0; req_addr = '0; req_wdata = '0; req_read = 1'b0; req_write = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", LINE_W'(req_ready), '0);
        check("reset_hit", LINE_W'(req_hit), '0);
        check("reset_rdata", LINE_W'(req_rdata), '0);
        check("reset_mem_req", LINE_W'({mem_read, mem_write}), '0);
        check("reset_mem_addr", LINE_W'(mem_addr), '0);
        rst_n = 1'b1;

        // Cold read: one fill from the line-aligned address.
        do_req("cold_read", 32'h104, 1, 0, '0, 0, sub_of(pattern_line(32'h100), 4), 0, 1);
        if (mem_log.size() == 1) begin
            check("cold_fill_addr", LINE_W'(mem_log[0].addr), LINE_W'(32'h100));
            check("cold_fill_is_read", LINE_W'(mem_log[0].wr), '0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            do_req(vecs[i].name, vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wd,
                   vecs[i].hit, vecs[i].rdata, vecs[i].lat, vecs[i].ops);
        end

        // Fill the rest of set 0, then force a dirty eviction of way 0 via the pointer.
        do_req("fill_tag3", 32'h300, 1, 0, '0, 0, sub_of(pattern_line(32'h300), 0), 0, 1);
        do_req("fill_tag4", 32'h400, 1, 0, '0, 0, sub_of(pattern_line(32'h400), 0), 0, 1);
        wb_line = pattern_line(32'h100);
        wb_line[8*32 +: SUB_W]  = wa;
        wb_line[12*32 +: SUB_W] = we;
        do_req("evict_dirty", 32'h500, 1, 0, '0, 0, sub_of(pattern_line(32'h500), 0), 0, 2);
        if (mem_log.size() == 2) begin
            check("wb_is_write", LINE_W'(mem_log[0].wr), LINE_W'(1'b1));
            check("wb_addr", LINE_W'(mem_log[0].addr), LINE_W'(32'h100));
            check("wb_line", mem_log[0].data, wb_line);
            check("wb_then_read", LINE_W'(mem_log[1].wr), '0);
            check("wb_fill_addr", LINE_W'(mem_log[1].addr), LINE_W'(32'h500));
        end
        // Pointer now at way 1 (clean tag 2): fill only, no write-back.
        do_req("evict_ptr1", 32'h600, 1, 0, '0, 0, sub_of(pattern_line(32'h600), 0), 0, 1);
        if (mem_log.size() == 1) begin
            check("ptr1_fill_addr", LINE_W'(mem_log[0].addr), LINE_W'(32'h600));
        end
        do_req("refetch_104", 32'h104, 1, 0, '0, 0, sub_of(wb_line, 4), 0, 1);
        do_req("refetch_108", 32'h108, 1, 0, '0, 1, wa, 0, 0);

        // Reset while a fill is outstanding.
        @(negedge clk);
        mem_hold  = 1'b1;
        req_addr  = 32'h700;
        req_read  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_read && n < 50);
        check("fill_started", LINE_W'(mem_read), LINE_W'(1'b1));
        rst_n    = 1'b0;
        req_read = 1'b0;
        @(negedge clk);
        check("rst_mid_mem_read", LINE_W'(mem_read), '0);
        check("rst_mid_ready", LINE_W'(req_ready), '0);
        rst_n    = 1'b1;
        mem_hold = 1'b0;
        do_req("post_rst_miss", 32'h104, 1, 0, '0, 0, sub_of(wb_line, 4), 0, 1);
        do_req("post_rst_hit", 32'h108, 1, 0, '0, 1, wa, 3, 0);

        repeat (2) @(negedge clk);
        check("no_rd_wr_overlap", LINE_W'(overlap), '0);
        check("scoreboard_drained", LINE_W'(sb_q.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
